// File: rtl/mux_operation_pkg.sv
// mux_operation_pkg: shared constants and the op-code enum for the
// registered operation multiplexer.
//   DATA_W  : operand/result width (only 32 is verified)
//   SHAMT_W : shift-amount width taken from the low bits of B
//   op_e    : 4-bit operation select encoding
package mux_operation_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_AND    = 4'd3,
    OP_OR     = 4'd4,
    OP_XOR    = 4'd5,
    OP_SLL    = 4'd6,
    OP_SRL    = 4'd7,
    OP_SRA    = 4'd8,
    OP_SLT    = 4'd9,
    OP_SLTU   = 4'd10,
    OP_MAXU   = 4'd11,
    OP_MINU   = 4'd12,
    OP_PASS_A = 4'd13,
    OP_PASS_B = 4'd14,
    OP_NOT_A  = 4'd15
  } op_e;

endpackage

// File: rtl/mux_operation_if.sv
// mux_operation_if: bus between the register wrapper (master) and the
// operation multiplexer (slave).
//   A, B     : operands              (master -> slave)
//   S        : operation select      (master -> slave)
//   r_ready  : request level, rising edge starts one operation
//   ans      : registered result     (slave -> master)
//   w_ready  : one-clock result-valid strobe
interface mux_operation_if #(
  parameter int DATA_W = mux_operation_pkg::DATA_W
);
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [3:0]        S;
  logic              r_ready;
  logic [DATA_W-1:0] ans;
  logic              w_ready;

  modport master (output A, B, S, r_ready, input  ans, w_ready);
  modport slave  (input  A, B, S, r_ready, output ans, w_ready);
endinterface

// File: rtl/mux_operation_alu.sv
// mux_operation_alu: purely combinational operation decode.
//   i_a, i_b : operands
//   i_s      : operation select (op_e encoding)
//   o_result : f(A, B, S)
// Optional feature: define MUX_OPERATION_MUL_EN to build the 32x32
// multiplier for OP_MUL; otherwise OP_MUL yields zero.
module mux_operation_alu
  import mux_operation_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_s,
  output logic [DATA_W-1:0] o_result
);

  logic [SHAMT_W-1:0] w_shamt;
  logic [DATA_W-1:0]  w_mul;

  assign w_shamt = i_b[SHAMT_W-1:0];

`ifdef MUX_OPERATION_MUL_EN
  // Product truncated to DATA_W bits: wraps modulo 2^DATA_W.
  assign w_mul = i_a * i_b;
`else
  assign w_mul = '0;
`endif

  always_comb begin
    o_result = '0;
    case (op_e'(i_s))
      OP_ADD:    o_result = i_a + i_b;
      OP_SUB:    o_result = i_a - i_b;
      OP_MUL:    o_result = w_mul;
      OP_AND:    o_result = i_a & i_b;
      OP_OR:     o_result = i_a | i_b;
      OP_XOR:    o_result = i_a ^ i_b;
      OP_SLL:    o_result = i_a << w_shamt;
      OP_SRL:    o_result = i_a >> w_shamt;
      OP_SRA:    o_result = DATA_W'($signed(i_a) >>> w_shamt);
      OP_SLT:    o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU:   o_result = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
      OP_MAXU:   o_result = (i_a > i_b) ? i_a : i_b;
      OP_MINU:   o_result = (i_a < i_b) ? i_a : i_b;
      OP_PASS_A: o_result = i_a;
      OP_PASS_B: o_result = i_b;
      OP_NOT_A:  o_result = ~i_a;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/mux_operation.sv
// mux_operation: registered operation multiplexer.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mux_operation_if.slave (A, B, S, r_ready in; ans, w_ready out)
// A rising edge on r_ready samples A/B/S, registers the result on ans and
// pulses w_ready for one clock. ans holds between requests.
// Optional feature: MUX_OPERATION_MUL_EN (see mux_operation_alu).
module mux_operation
  import mux_operation_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mux_operation_if.slave   bus
);

  logic              r_req_d;
  logic              r_w_ready;
  logic [DATA_W-1:0] r_ans;
  logic              w_req;
  logic [DATA_W-1:0] w_result;

  // req_d resets low, so r_ready already high at release counts as a request.
  assign w_req = bus.r_ready & ~r_req_d;

  mux_operation_alu u_alu (
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_s      (bus.S),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_d   <= 1'b0;
      r_w_ready <= 1'b0;
      r_ans     <= '0;
    end else begin
      r_req_d   <= bus.r_ready;
      r_w_ready <= w_req;
      if (w_req) r_ans <= w_result;
    end
  end

  assign bus.ans     = r_ans;
  assign bus.w_ready = r_w_ready;

endmodule

// File: tb/tb_mux_operation.sv
module tb_mux_operation;
  import mux_operation_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux_operation_if bus ();

  mux_operation dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request/response: raise r_ready, check pulse and result, drop r_ready,
  // check the pulse ended and the result held.
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s, input logic [31:0] exp);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.S = s; bus.r_ready = 1'b1;
    @(posedge clk); #1;
    check($sformatf("vec%0d w_ready pulse", idx), {31'b0, bus.w_ready}, 32'd1);
    check($sformatf("vec%0d ans S=%0d", idx, s), bus.ans, exp);
    @(negedge clk);
    bus.r_ready = 1'b0;
    bus.A = ~a; bus.S = s + 4'd1;   // disturb inputs without a request
    @(posedge clk); #1;
    check($sformatf("vec%0d w_ready low", idx), {31'b0, bus.w_ready}, 32'd0);
    check($sformatf("vec%0d ans hold", idx), bus.ans, exp);
  endtask

  initial begin
    int pulses;
    logic [31:0] mul_exp;
`ifdef MUX_OPERATION_MUL_EN
    mul_exp = 32'd200;
`else
    mul_exp = 32'd0;
`endif
    vecs.push_back('{32'd10, 32'd20, 4'd0, 32'd30});
    vecs.push_back('{32'd10, 32'd20, 4'd1, 32'hFFFF_FFF6});
    vecs.push_back('{32'd10, 32'd20, 4'd2, mul_exp});
    vecs.push_back('{32'd10, 32'd20, 4'd3, 32'd0});
    vecs.push_back('{32'd10, 32'd20, 4'd4, 32'd30});
    vecs.push_back('{32'd10, 32'd20, 4'd5, 32'd30});
    vecs.push_back('{32'h0000_0003, 32'd4, 4'd6, 32'h0000_0030});
    vecs.push_back('{32'h8000_0000, 32'd4, 4'd7, 32'h0800_0000});
    vecs.push_back('{32'h8000_0000, 32'd4, 4'd8, 32'hF800_0000});
    vecs.push_back('{32'h8000_0000, 32'd4, 4'd9, 32'd1});
    vecs.push_back('{32'h8000_0000, 32'd4, 4'd10, 32'd0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 4'd11, 32'hFFFF_FFFF});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 4'd12, 32'd1});
    vecs.push_back('{32'h8000_0000, 32'd4, 4'd13, 32'h8000_0000});
    vecs.push_back('{32'h8000_0000, 32'd4, 4'd14, 32'd4});
    vecs.push_back('{32'h8000_0000, 32'd4, 4'd15, 32'h7FFF_FFFF});
    vecs.push_back('{32'h0000_0001, 32'h0000_0025, 4'd6, 32'h0000_0020}); // only B[4:0]

    // Reset with r_ready already high.
    rst = 1'b1;
    bus.A = 32'd10; bus.B = 32'd20; bus.S = 4'd0; bus.r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset ans", bus.ans, 32'd0);
    check("reset w_ready", {31'b0, bus.w_ready}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset w_ready", {31'b0, bus.w_ready}, 32'd1);
    check("post-reset ans", bus.ans, 32'd30);
    @(posedge clk); #1;
    check("post-reset single pulse", {31'b0, bus.w_ready}, 32'd0);
    @(negedge clk) bus.r_ready = 1'b0;
    @(posedge clk);

    foreach (vecs[i]) do_op(i, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);

    // r_ready held for 10 clocks: one pulse; S changes during hold are ignored.
    pulses = 0;
    @(negedge clk);
    bus.A = 32'd5; bus.B = 32'd3; bus.S = 4'd0; bus.r_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.w_ready) pulses++;
      if (c == 2) bus.S = 4'd5;
    end
    check("hold pulse count", pulses, 32'd1);
    check("hold ans unchanged", bus.ans, 32'd8);
    @(negedge clk) bus.r_ready = 1'b0;
    @(posedge clk);

    // Reset asserted while a result is being presented.
    @(negedge clk);
    bus.A = 32'd7; bus.B = 32'd7; bus.S = 4'd0; bus.r_ready = 1'b1;
    @(posedge clk); #1;
    check("midop pulse", {31'b0, bus.w_ready}, 32'd1);
    check("midop ans", bus.ans, 32'd14);
    #1 rst = 1'b1;
    #1;
    check("midop reset ans", bus.ans, 32'd0);
    check("midop reset w_ready", {31'b0, bus.w_ready}, 32'd0);
    @(negedge clk) begin rst = 1'b0; bus.r_ready = 1'b0; end
    @(posedge clk);

    // Reset coincident with a request edge: reset wins.
    @(negedge clk) begin rst = 1'b1; bus.r_ready = 1'b1; bus.S = 4'd13; end
    @(posedge clk); #1;
    check("coincident w_ready", {31'b0, bus.w_ready}, 32'd0);
    check("coincident ans", bus.ans, 32'd0);
    @(negedge clk) begin rst = 1'b0; bus.r_ready = 1'b0; end
    @(posedge clk); #1;
    check("idle w_ready", {31'b0, bus.w_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
